// File: rtl/cache_fill_ctrl_if.sv
// Memory-side request/response bus of the cache line-fill controller.
// master = fill controller, slave = memory.
interface cache_fill_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic [ADDR_W-1:0] memory_address;
    logic              mem_gnt;
    logic              memory_data_valid;

    modport master (
        output mem_req,
        output memory_address,
        input  mem_gnt,
        input  memory_data_valid
    );

    modport slave (
        input  mem_req,
        input  memory_address,
        output mem_gnt,
        output memory_data_valid
    );
endinterface

// File: rtl/cache_fill_ctrl.sv
// Cache line-fill controller: on a miss, requests every word of the line
// (optionally critical-word-first), writes the in-order responses, then pulses tag_wen.
module cache_fill_ctrl #(
    parameter  int ADDR_W     = 16,
    parameter  int WORDS      = 8,
    parameter  int WORD_BYTES = 2,
    parameter  int CWF        = 0,
    localparam int OFF_W      = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              miss_detected,
    input  logic [ADDR_W-1:0] miss_address,
    cache_fill_ctrl_if.master mem,
    output logic              fsm_busy,
    output logic              data_wen,
    output logic [OFF_W-1:0]  data_word_idx,
    output logic              tag_wen
);
    localparam int             BYTE_W     = $clog2(WORD_BYTES);
    localparam int             BASE_W     = ADDR_W - OFF_W - BYTE_W;
    localparam logic [OFF_W:0] LINE_WORDS = (OFF_W+1)'(WORDS);
    localparam logic [OFF_W:0] CNT_ONE    = (OFF_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } state_e;

    state_e            state_q;
    logic [OFF_W:0]    req_cnt_q;
    logic [OFF_W:0]    rsp_cnt_q;
    logic [BASE_W-1:0] line_base_q;
    logic [OFF_W-1:0]  start_q;

    logic              req_fire;
    logic              rsp_acc;
    logic [OFF_W-1:0]  req_idx;
    logic [OFF_W-1:0]  rsp_idx;

    // Word indices wrap naturally in OFF_W bits, giving the modulo-WORDS order.
    always_comb begin
        fsm_busy           = (state_q != IDLE);
        tag_wen            = (state_q == DONE);
        mem.mem_req        = (state_q == FILL) && (req_cnt_q < LINE_WORDS);
        req_fire           = mem.mem_req && mem.mem_gnt;
        rsp_acc            = mem.memory_data_valid && (state_q == FILL) && (rsp_cnt_q < req_cnt_q);
        req_idx            = start_q + req_cnt_q[OFF_W-1:0];
        rsp_idx            = start_q + rsp_cnt_q[OFF_W-1:0];
        mem.memory_address = mem.mem_req ? (ADDR_W'({line_base_q, req_idx}) << BYTE_W) : '0;
        data_wen           = rsp_acc;
        data_word_idx      = rsp_acc ? rsp_idx : '0;
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            req_cnt_q   <= '0;
            rsp_cnt_q   <= '0;
            line_base_q <= '0;
            start_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss_detected) begin
                        state_q     <= FILL;
                        line_base_q <= miss_address[ADDR_W-1:OFF_W+BYTE_W];
                        start_q     <= (CWF != 0) ? miss_address[OFF_W+BYTE_W-1:BYTE_W] : '0;
                    end
                end
                FILL: begin
                    if (req_fire) begin
                        req_cnt_q <= req_cnt_q + CNT_ONE;
                    end
                    if (rsp_acc) begin
                        rsp_cnt_q <= rsp_cnt_q + CNT_ONE;
                        if (rsp_cnt_q == LINE_WORDS - CNT_ONE) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    req_cnt_q <= '0;
                    rsp_cnt_q <= '0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Randomized bench for cache_fill_ctrl: a CWF=0 and a CWF=1 instance share the
// same stimulus and are compared every cycle against a queue-based line-fill model.
module tb_cache_fill_ctrl;
    localparam int AW    = 16;
    localparam int WORDS = 8;
    localparam int WB    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          miss_detected;
    logic [AW-1:0] miss_address;
    logic [1:0]    busy, wen, tag;
    logic [2:0]    idx0, idx1;

    cache_fill_ctrl_if #(.ADDR_W(AW)) bus0 ();
    cache_fill_ctrl_if #(.ADDR_W(AW)) bus1 ();

    cache_fill_ctrl #(.ADDR_W(AW), .WORDS(WORDS), .WORD_BYTES(WB), .CWF(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
        .mem(bus0.master), .fsm_busy(busy[0]), .data_wen(wen[0]), .data_word_idx(idx0), .tag_wen(tag[0])
    );
    cache_fill_ctrl #(.ADDR_W(AW), .WORDS(WORDS), .WORD_BYTES(WB), .CWF(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .miss_detected(miss_detected), .miss_address(miss_address),
        .mem(bus1.master), .fsm_busy(busy[1]), .data_wen(wen[1]), .data_word_idx(idx1), .tag_wen(tag[1])
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: phase 0 idle, 1 filling, 2 tag-write cycle.
    int ph = 0;
    int base = 0;
    int start[2] = '{0, 0};
    int issued = 0;
    int accepted = 0;
    int pend[$];
    int due[$];
    int lat = 2;
    int cyc = 0;
    int wen_cnt = 0;

    task automatic check_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic m, input logic [AW-1:0] a,
                        input logic g, input logic spur, input bit do_chk);
        logic v;
        logic e_req, e_wen;
        int   e_addr, e_idx;
        logic [31:0] got_addr, got_idx;
        v = spur;
        while (due.size() > 0 && due[0] <= cyc) begin
            v = 1'b1;
            void'(due.pop_front());
        end
        rst_n                  = r;
        miss_detected          = m;
        miss_address           = a;
        bus0.mem_gnt           = g;
        bus1.mem_gnt           = g;
        bus0.memory_data_valid = v;
        bus1.memory_data_valid = v;
        #1;
        e_req = (ph == 1) && (issued < WORDS);
        e_wen = (ph == 1) && v && (pend.size() > 0);
        if (do_chk) begin
            for (int i = 0; i < 2; i++) begin
                e_addr   = e_req ? base + ((start[i] + issued) % WORDS) * WB : 0;
                e_idx    = e_wen ? (start[i] + pend[0]) % WORDS : 0;
                got_addr = (i == 0) ? 32'(bus0.memory_address) : 32'(bus1.memory_address);
                got_idx  = (i == 0) ? 32'(idx0) : 32'(idx1);
                check_eq($sformatf("busy%0d", i), 32'(busy[i]), 32'(ph != 0));
                check_eq($sformatf("tag_wen%0d", i), 32'(tag[i]), 32'(ph == 2));
                check_eq($sformatf("mem_req%0d", i), (i == 0) ? 32'(bus0.mem_req) : 32'(bus1.mem_req), 32'(e_req));
                check_eq($sformatf("addr%0d", i), got_addr, 32'(e_addr));
                check_eq($sformatf("data_wen%0d", i), 32'(wen[i]), 32'(e_wen));
                check_eq($sformatf("word_idx%0d", i), got_idx, 32'(e_idx));
            end
        end
        if (e_wen) wen_cnt++;
        if (r) begin
            ph = 0; base = 0; start = '{0, 0}; issued = 0; accepted = 0;
            pend.delete();
        end else begin
            case (ph)
                0: if (m) begin
                    ph       = 1;
                    base     = (int'(a) / (WORDS * WB)) * (WORDS * WB);
                    start[0] = 0;
                    start[1] = (int'(a) / WB) % WORDS;
                    issued   = 0;
                    accepted = 0;
                    pend.delete();
                end
                1: begin
                    if (e_wen) begin
                        void'(pend.pop_front());
                        accepted++;
                        if (accepted == WORDS) ph = 2;
                    end
                    if (e_req && g) begin
                        pend.push_back(issued);
                        issued++;
                        due.push_back(cyc + lat);
                    end
                end
                default: ph = 0;
            endcase
        end
        cyc++;
        @(negedge clk);
    endtask

    // One complete fill: miss in cycle 0, then run until the model is idle again.
    task automatic run_fill(input logic [AW-1:0] a, input int gpct, input int lat_i,
                            input int spur_pct, input int spur_k,
                            input logic hold_m, input logic [AW-1:0] hold_a,
                            input int ng_lo, input int ng_hi, input int exp_len);
        int   k;
        int   w0;
        logic g, sp;
        lat = lat_i;
        w0  = wen_cnt;
        step(1'b0, 1'b1, a, 1'b1, 1'b0, 1'b1);
        k = 1;
        while (ph != 0 && k < 300) begin
            g  = ($urandom_range(99) < gpct) && !(k >= ng_lo && k <= ng_hi);
            sp = ($urandom_range(99) < spur_pct) || (k == spur_k);
            step(1'b0, hold_m, hold_a, g, sp, 1'b1);
            k++;
        end
        check_eq("fill_in_budget", 32'(k < 300), 32'd1);
        check_eq("wen_pulses", 32'(wen_cnt - w0), 32'(WORDS));
        if (exp_len > 0) check_eq("fill_len", 32'(k), 32'(exp_len));
    endtask

    initial begin
        int k;
        bus0.mem_gnt = 1'b0; bus1.mem_gnt = 1'b0;
        bus0.memory_data_valid = 1'b0; bus1.memory_data_valid = 1'b0;
        @(negedge clk);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Plain fill: miss 0x1234 (CWF=1 instance starts at word 2), full grant, latency 2.
        run_fill(16'h1234, 100, 2, 0, -1, 1'b0, '0, -1, -1, 12);
        // Miss 0x1236: critical word 3 first on the CWF=1 instance.
        run_fill(16'h1236, 100, 2, 0, -1, 1'b0, '0, -1, -1, 12);
        // Grant withheld in cycles 2-4.
        run_fill(16'h1234, 100, 2, 0, -1, 1'b0, '0, 2, 4, 15);
        // Valid in the first fill cycle, before any grant.
        run_fill(16'h1234, 100, 2, 0, 1, 1'b0, '0, 1, 1, -1);
        // A second miss held through FILL and DONE, then taken in the following IDLE cycle.
        run_fill(16'h1234, 100, 2, 0, -1, 1'b1, 16'h5670, -1, -1, 12);
        run_fill(16'h5670, 100, 2, 0, -1, 1'b0, '0, -1, -1, 12);

        // Reset after 3 accepted responses, then stray responses.
        lat = 2;
        step(1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b1);
        k = 0;
        while (accepted < 3 && k < 50) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
            k++;
        end
        check_eq("reached_3_rsp", 32'(accepted), 32'd3);
        step(1'b1, 1'b0, '0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
        due.delete();

        // Random fills with random grant density, latency and stray valids.
        for (int n = 0; n < 30; n++) begin
            for (int j = 0; j < int'($urandom_range(3)); j++)
                step(1'b0, 1'b0, 16'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            run_fill(16'($urandom), int'($urandom_range(30, 100)), int'($urandom_range(1, 4)),
                     int'($urandom_range(15)), -1, 1'($urandom), 16'($urandom), -1, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
